// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: tracks start/data/parity/stop bits from the
// external edge/bit counter and strobes the sampler, deserializer and checkers.
module uart_rx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_RX,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [3:0]            bit_cnt,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  edge_cnt_enable,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  par_err_o,
  output logic                  stp_err_o,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

  state_t                state, nxt;
  logic                  par_en_r, perr_r;
  logic [PRESCALE_W-1:0] p_eff, chk_pt, end_pt;
  logic                  at_chk, at_end, go_done;

  // Anything other than 16 or 32 runs as 8x oversampling.
  always_comb begin
    case (prescale)
      PRESCALE_W'(16): p_eff = PRESCALE_W'(16);
      PRESCALE_W'(32): p_eff = PRESCALE_W'(32);
      default:         p_eff = PRESCALE_W'(8);
    endcase
  end

  assign chk_pt  = (p_eff >> 1) + PRESCALE_W'(1);
  assign end_pt  = p_eff - PRESCALE_W'(1);
  assign at_chk  = (edge_cnt == chk_pt);
  assign at_end  = (edge_cnt == end_pt);
  assign go_done = (state == STOP) && at_chk;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt             = state;
    edge_cnt_enable = 1'b0;
    dat_samp_en     = 1'b0;
    deser_en        = 1'b0;
    strt_chk_en     = 1'b0;
    par_chk_en      = 1'b0;
    stp_chk_en      = 1'b0;
    case (state)
      IDLE: if (!RX_IN) nxt = START;
      START: begin
        edge_cnt_enable = 1'b1;
        dat_samp_en     = 1'b1;
        strt_chk_en     = at_chk;
        if (at_chk && strt_glitch) nxt = IDLE;
        else if (at_end)           nxt = DATA;
      end
      DATA: begin
        edge_cnt_enable = 1'b1;
        dat_samp_en     = 1'b1;
        deser_en        = at_chk;
        if (at_end && bit_cnt == LAST_BIT) nxt = par_en_r ? PARITY : STOP;
      end
      PARITY: begin
        edge_cnt_enable = 1'b1;
        dat_samp_en     = 1'b1;
        par_chk_en      = at_chk;
        if (at_end) nxt = STOP;
      end
      STOP: begin
        edge_cnt_enable = 1'b1;
        dat_samp_en     = 1'b1;
        stp_chk_en      = at_chk;
        // Leave at mid stop-bit so a back-to-back start edge is seen from DONE.
        if (at_chk) nxt = DONE;
      end
      DONE:    nxt = RX_IN ? IDLE : START;
      default: nxt = IDLE;
    endcase
  end

  // Result flags are registered on the STOP->DONE transition, so they are
  // high exactly during the DONE cycle.
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      par_en_r   <= 1'b0;
      perr_r     <= 1'b0;
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      stp_err_o  <= 1'b0;
    end else begin
      data_valid <= go_done && !perr_r && !stp_err;
      par_err_o  <= go_done && perr_r;
      stp_err_o  <= go_done && stp_err;
      if ((state == IDLE || state == DONE) && !RX_IN) par_en_r <= PAR_EN;
      if (state == DONE)   perr_r <= 1'b0;
      else if (par_chk_en) perr_r <= par_err;
    end
  end

endmodule
